half_duplex_uart_responder: RTL

- ESC-side endpoint of the single-wire half-duplex serial link used in passthrough mode.
- Receives 8N1 bytes from the shared line and presents them on a valid pulse.
- Queues response bytes from local logic and transmits them only after a guard interval of line idle.
- Releases the line after each burst. Used as a synthesizable ESC/bootloader model and as the line endpoint for loopback tests.

---
 rtl/half_duplex_uart_responder.sv | 349 ++++++++++++++++++++++++++++++++++
 1 files changed

// File: rtl/half_duplex_uart_responder.sv
// ESC-side endpoint of a single-wire half-duplex 8N1 link: receives bytes, queues responses,
// and transmits them after a line-idle guard interval. Optional macro: HDUPLEX_BREAK_DETECT_EN.
module half_duplex_uart_responder #(
  parameter int CLK_FREQ_HZ     = 72_000_000,
  parameter int BAUD_RATE       = 115200,
  parameter int TX_FIFO_DEPTH   = 16,
  parameter int TURNAROUND_BITS = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       serial_in,
  output logic       serial_out,
  output logic       serial_oe,
  output logic [7:0] rx_data,
  output logic       rx_valid,
  output logic       rx_frame_err,
  input  logic [7:0] tx_data,
  input  logic       tx_valid,
  output logic       tx_ready,
  output logic       busy
`ifdef HDUPLEX_BREAK_DETECT_EN
  ,
  output logic       break_det
`endif
);

  localparam int BIT_CLKS   = (CLK_FREQ_HZ + BAUD_RATE / 2) / BAUD_RATE;
  localparam int HALF_CLKS  = BIT_CLKS / 2;
  localparam int GUARD_CLKS = TURNAROUND_BITS * BIT_CLKS;
  localparam int BW         = $clog2(BIT_CLKS + 1);
  localparam int GW         = $clog2(GUARD_CLKS + 1);
  localparam int AW         = (TX_FIFO_DEPTH > 1) ? $clog2(TX_FIFO_DEPTH) : 1;

  localparam logic [BW-1:0] BIT_LAST  = BW'(BIT_CLKS - 1);
  localparam logic [BW-1:0] HALF_LAST = BW'(HALF_CLKS - 1);
  localparam logic [GW-1:0] GUARD_SAT = GW'(GUARD_CLKS);
  localparam logic [AW:0]   FIFO_FULL = (AW + 1)'(TX_FIFO_DEPTH);

  typedef enum logic [2:0] {
    R_IDLE      = 3'd0,
    R_START     = 3'd1,
    R_DATA      = 3'd2,
    R_STOP      = 3'd3,
    R_WAIT_HIGH = 3'd4
  } rx_state_t;

  typedef enum logic [2:0] {
    T_IDLE  = 3'd0,
    T_GUARD = 3'd1,
    T_START = 3'd2,
    T_DATA  = 3'd3,
    T_STOP  = 3'd4
  } tx_state_t;

  logic            r_sync1, r_sync2, r_line_d;
  rx_state_t       r_rx_state;
  logic [BW-1:0]   r_rx_cnt;
  logic [2:0]      r_rx_bit;
  logic [7:0]      r_rx_shift;
  logic [7:0]      r_rx_data;
  logic            r_rx_valid, r_rx_err;
  logic [GW-1:0]   r_idle_cnt;
  tx_state_t       r_tx_state;
  logic [BW-1:0]   r_tx_cnt;
  logic [2:0]      r_tx_bit;
  logic [7:0]      r_tx_shift;
  logic            r_serial_out, r_serial_oe;
  logic [7:0]      r_mem [TX_FIFO_DEPTH];
  logic [AW-1:0]   r_wr_ptr, r_rd_ptr;
  logic [AW:0]     r_count;

  logic            w_line, w_fall, w_idle_sat, w_empty, w_full;
  logic            w_push, w_pop, w_break;
  logic [7:0]      w_rdata;

  assign w_line     = r_sync2;
  assign w_fall     = r_line_d & ~r_sync2;
  assign w_idle_sat = (r_idle_cnt == GUARD_SAT);
  assign w_empty    = (r_count == '0);
  assign w_full     = (r_count == FIFO_FULL);
  assign w_rdata    = r_mem[r_rd_ptr];

  // A full FIFO still accepts a byte in the cycle the transmitter pops one.
  assign tx_ready     = (~w_full | w_pop) & ~w_break;
  assign w_push       = tx_valid & tx_ready;
  assign busy         = (r_rx_state != R_IDLE) || (r_tx_state != T_IDLE);
  assign serial_out   = r_serial_out;
  assign serial_oe    = r_serial_oe;
  assign rx_data      = r_rx_data;
  assign rx_valid     = r_rx_valid;
  assign rx_frame_err = r_rx_err;

  // Pop is the entry condition into T_START from either T_GUARD or T_STOP.
  always_comb begin
    w_pop = 1'b0;
    case (r_tx_state)
      T_GUARD: w_pop = w_idle_sat & ~w_empty;
      T_STOP:  w_pop = (r_tx_cnt == BIT_LAST) & ~w_empty;
      default: w_pop = 1'b0;
    endcase
  end

`ifdef HDUPLEX_BREAK_DETECT_EN
  localparam int BRK_CLKS = 10 * BIT_CLKS;
  localparam int LW       = $clog2(BRK_CLKS + 1);
  localparam logic [LW-1:0] BRK_LAST = LW'(BRK_CLKS - 1);
  localparam logic [LW-1:0] BRK_SAT  = LW'(BRK_CLKS);

  logic [LW-1:0] r_low_cnt;
  logic          r_break_det;

  assign w_break   = ~w_line & ~r_serial_oe & (r_low_cnt == BRK_LAST);
  assign break_det = r_break_det;

  // Low-time counter saturates so a held break yields a single pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_low_cnt   <= '0;
      r_break_det <= 1'b0;
    end else begin
      r_break_det <= w_break;
      if (w_line || r_serial_oe) begin
        r_low_cnt <= '0;
      end else if (r_low_cnt != BRK_SAT) begin
        r_low_cnt <= r_low_cnt + 1'b1;
      end else begin
        r_low_cnt <= r_low_cnt;
      end
    end
  end
`else
  assign w_break = 1'b0;
`endif

  // Two-flop synchronizer on the pad, idle-high.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_sync1  <= 1'b1;
      r_sync2  <= 1'b1;
      r_line_d <= 1'b1;
    end else begin
      r_sync1  <= serial_in;
      r_sync2  <= r_sync1;
      r_line_d <= r_sync2;
    end
  end

  // Receiver; held idle while we drive the line so our own echo is ignored.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_rx_state <= R_IDLE;
      r_rx_cnt   <= '0;
      r_rx_bit   <= 3'd0;
      r_rx_shift <= 8'h00;
      r_rx_data  <= 8'h00;
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
    end else begin
      r_rx_valid <= 1'b0;
      r_rx_err   <= 1'b0;
      if (r_serial_oe) begin
        r_rx_state <= R_IDLE;
        r_rx_cnt   <= '0;
      end else if (w_break) begin
        r_rx_state <= R_WAIT_HIGH;
        r_rx_cnt   <= '0;
      end else begin
        case (r_rx_state)
          R_IDLE: begin
            r_rx_cnt <= '0;
            if (w_fall) begin
              r_rx_state <= R_START;
            end
          end
          R_START: begin
            if (r_rx_cnt == HALF_LAST) begin
              r_rx_cnt   <= '0;
              r_rx_bit   <= 3'd0;
              r_rx_state <= w_line ? R_IDLE : R_DATA;
            end else begin
              r_rx_cnt <= r_rx_cnt + 1'b1;
            end
          end
          R_DATA: begin
            if (r_rx_cnt == BIT_LAST) begin
              r_rx_cnt   <= '0;
              r_rx_shift <= {w_line, r_rx_shift[7:1]};
              r_rx_bit   <= r_rx_bit + 3'd1;
              if (r_rx_bit == 3'd7) begin
                r_rx_state <= R_STOP;
              end
            end else begin
              r_rx_cnt <= r_rx_cnt + 1'b1;
            end
          end
          R_STOP: begin
            if (r_rx_cnt == BIT_LAST) begin
              r_rx_cnt <= '0;
              if (w_line) begin
                r_rx_data  <= r_rx_shift;
                r_rx_valid <= 1'b1;
                r_rx_state <= R_IDLE;
              end else begin
                r_rx_err   <= 1'b1;
                r_rx_state <= R_WAIT_HIGH;
              end
            end else begin
              r_rx_cnt <= r_rx_cnt + 1'b1;
            end
          end
          R_WAIT_HIGH: begin
            r_rx_cnt <= '0;
            if (w_line) begin
              r_rx_state <= R_IDLE;
            end
          end
          default: begin
            r_rx_state <= R_IDLE;
            r_rx_cnt   <= '0;
          end
        endcase
      end
    end
  end

  // Line-idle time, measured only while the receiver is idle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_idle_cnt <= '0;
    end else if (w_line && (r_rx_state == R_IDLE)) begin
      if (!w_idle_sat) begin
        r_idle_cnt <= r_idle_cnt + 1'b1;
      end
    end else begin
      r_idle_cnt <= '0;
    end
  end

  // Response FIFO storage; contents are don't-care until written.
  always_ff @(posedge clk) begin
    if (w_push) begin
      r_mem[r_wr_ptr] <= tx_data;
    end
  end

  // FIFO pointers and occupancy; a break flushes everything.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (w_break) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      if (w_push) begin
        r_wr_ptr <= r_wr_ptr + 1'b1;
      end
      if (w_pop) begin
        r_rd_ptr <= r_rd_ptr + 1'b1;
      end
      case ({w_push, w_pop})
        2'b10:   r_count <= r_count + 1'b1;
        2'b01:   r_count <= r_count - 1'b1;
        default: r_count <= r_count;
      endcase
    end
  end

  // Transmitter; bursts back-to-back bytes without releasing the line.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_tx_state   <= T_IDLE;
      r_tx_cnt     <= '0;
      r_tx_bit     <= 3'd0;
      r_tx_shift   <= 8'h00;
      r_serial_out <= 1'b1;
      r_serial_oe  <= 1'b0;
    end else begin
      case (r_tx_state)
        T_IDLE: begin
          r_tx_cnt <= '0;
          if (!w_empty) begin
            r_tx_state <= T_GUARD;
          end
        end
        T_GUARD: begin
          if (w_empty) begin
            r_tx_state <= T_IDLE;
          end else if (w_idle_sat) begin
            r_serial_oe  <= 1'b1;
            r_serial_out <= 1'b0;
            r_tx_shift   <= w_rdata;
            r_tx_cnt     <= '0;
            r_tx_state   <= T_START;
          end
        end
        T_START: begin
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt     <= '0;
            r_tx_bit     <= 3'd0;
            r_serial_out <= r_tx_shift[0];
            r_tx_shift   <= {1'b0, r_tx_shift[7:1]};
            r_tx_state   <= T_DATA;
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        T_DATA: begin
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt <= '0;
            if (r_tx_bit == 3'd7) begin
              r_serial_out <= 1'b1;
              r_tx_state   <= T_STOP;
            end else begin
              r_tx_bit     <= r_tx_bit + 3'd1;
              r_serial_out <= r_tx_shift[0];
              r_tx_shift   <= {1'b0, r_tx_shift[7:1]};
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        T_STOP: begin
          if (r_tx_cnt == BIT_LAST) begin
            r_tx_cnt <= '0;
            if (!w_empty) begin
              r_serial_out <= 1'b0;
              r_tx_shift   <= w_rdata;
              r_tx_state   <= T_START;
            end else begin
              r_serial_oe <= 1'b0;
              r_tx_state  <= T_IDLE;
            end
          end else begin
            r_tx_cnt <= r_tx_cnt + 1'b1;
          end
        end
        default: begin
          r_tx_state   <= T_IDLE;
          r_serial_oe  <= 1'b0;
          r_serial_out <= 1'b1;
        end
      endcase
    end
  end

endmodule
